screen_draw_ctrl: RTL and testbench
===================================

SCREEN_DRAW_CTRL -- requirements
Module: screen_draw_ctrl

Interface
REQ-001 Parameter WIDTH, default 160, pixels per picture row.
REQ-002 Parameter HEIGHT, default 120, picture rows.
REQ-003 Parameter ROM_LAT, default 1, cycles from ROM address to valid q; legal values 1..3.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to draw one full picture; sampled only in IDLE.
REQ-007 pic_sel  input  2  picture selector sampled with start: 0 front, 1 startgame, 2 win, 3 lose.
REQ-008 abort  input  1  synchronous cancel of an in-progress draw.
REQ-009 q_front, q_start, q_win, q_lose  input  3 each  colour outputs of the four picture ROM loaders.
REQ-010 rom_x  output  8  column address driven to all picture loaders.
REQ-011 rom_y  output  7  row address driven to all picture loaders.
REQ-012 vga_x  output  8  plot column.
REQ-013 vga_y  output  7  plot row.
REQ-014 vga_colour  output  3  plot colour.
REQ-015 vga_plot  output  1  write strobe, one pixel per asserted cycle.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on completion of a full picture.

Function
REQ-018 States: IDLE, SCAN, DRAIN, DONE.
REQ-019 IDLE: start=1 latches pic_sel into sel_q, clears rom_x/rom_y to 0, and enters SCAN next cycle; start=0 keeps IDLE.
REQ-020 SCAN: one address per cycle in raster order; rom_x increments each cycle; at rom_x=WIDTH-1, rom_x wraps to 0 and rom_y increments.
REQ-021 SCAN: the cycle issuing (WIDTH-1, HEIGHT-1) transitions to DRAIN; rom_x/rom_y hold that value.
REQ-022 DRAIN: lasts exactly ROM_LAT cycles, then DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 A ROM_LAT-deep pipeline carries (x, y, valid) alongside each issued address; vga_x/vga_y/vga_plot equal the pipeline output.
REQ-025 vga_colour equals the q input selected by sel_q in the same cycle that vga_plot is high.
REQ-026 Each pixel (x,y) is plotted exactly once, ROM_LAT cycles after its address is issued.
REQ-027 A full draw plots exactly WIDTH*HEIGHT pixels; start-to-done latency is WIDTH*HEIGHT+ROM_LAT+1 cycles.
REQ-028 start and pic_sel changes are ignored while busy=1; sel_q is stable for the whole draw.
REQ-029 abort=1 in SCAN or DRAIN clears all pipeline valid bits the same edge, suppresses any further vga_plot, returns to IDLE next cycle, and produces no done pulse.
REQ-030 abort has no effect in IDLE or DONE; DONE always completes its pulse.
REQ-031 abort and start asserted together in IDLE: start wins.
REQ-032 vga_plot=0 whenever the pipeline output valid bit is 0; vga_x/vga_y/vga_colour are don't-care then.

Reset
REQ-033 Reset forces state IDLE and clears rom_x, rom_y, sel_q, and all pipeline valid bits; busy=0, done=0, and vga_plot=0 immediately (asynchronous).
REQ-034 Reset mid-draw produces no further plot and no done pulse; the first start after reset release behaves as after power-up.

Configuration
REQ-035 Macro TRANSPARENT_EN defined: pixels whose selected colour is 3'b000 are not plotted (vga_plot=0 for that slot); address sequencing, latency, and done timing are unchanged.
REQ-036 Macro TRANSPARENT_EN undefined: every pixel is plotted, including colour 3'b000.

Verification
REQ-037 start=1, pic_sel=2, ROM_LAT=1, win ROM q=x[2:0] -> 19200 plots, the first at (0,0) two cycles after start, last at (159,119), colour=x[2:0], done 19202 cycles after the start edge.
REQ-038 pic_sel toggled and start re-pulsed during draw -> no restart; all colours come from the originally latched picture; exactly one done.
REQ-039 abort at plot count 500 -> no plot after the abort edge, busy=0 one cycle later, no done; a subsequent start draws a full 19200-pixel picture.
REQ-040 reset asserted at pixel (80,60), mid-cycle -> vga_plot and busy fall without waiting for a clock edge; no done; the next start begins at (0,0).
REQ-041 TRANSPARENT_EN defined, lose ROM q=3'b000 on even x -> 9600 plots, all at odd x; done timing identical to REQ-037.
REQ-042 ROM_LAT=3 -> each plot's (x,y) lags its address by 3 cycles; done 19204 cycles after the start edge.

Source files
------------

// File: rtl/screen_draw_ctrl.sv
// Raster-scans one of four picture ROMs and streams (x, y, colour) plot strobes.
// Build option: `define TRANSPARENT_EN to suppress plots whose colour is 3'b000.
module screen_draw_ctrl #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int ROM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pic_sel,
  input  logic       abort,
  input  logic [2:0] q_front,
  input  logic [2:0] q_start,
  input  logic [2:0] q_win,
  input  logic [2:0] q_lose,
  output logic [7:0] rom_x,
  output logic [6:0] rom_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  // Handshake: start is a level request taken only while busy=0 (IDLE); once
  // taken, busy stays high until the cycle after the single-cycle done pulse.
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST   = 7'(HEIGHT - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(ROM_LAT - 1);

  state_t     state, state_nx;
  logic [1:0] sel_q;
  logic [1:0] drain_cnt;
  logic       last_addr;
  logic       kill;

  logic [7:0]         px [ROM_LAT];
  logic [6:0]         py [ROM_LAT];
  logic [ROM_LAT-1:0] pv;

  assign last_addr = (rom_x == X_LAST) && (rom_y == Y_LAST);
  assign kill      = abort && ((state == SCAN) || (state == DRAIN));
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = SCAN;
      end
      SCAN: begin
        if (abort)          state_nx = IDLE;
        else if (last_addr) state_nx = DRAIN;
      end
      DRAIN: begin
        if (abort)                        state_nx = IDLE;
        else if (drain_cnt == DRAIN_LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= 2'd0;
      rom_x     <= 8'd0;
      rom_y     <= 7'd0;
      drain_cnt <= 2'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            sel_q <= pic_sel;
            rom_x <= 8'd0;
            rom_y <= 7'd0;
          end
        end
        SCAN: begin
          drain_cnt <= 2'd0;
          // The final address is held through DRAIN so rom_x/rom_y stay put.
          if (!abort && !last_addr) begin
            if (rom_x == X_LAST) begin
              rom_x <= 8'd0;
              rom_y <= rom_y + 7'd1;
            end else begin
              rom_x <= rom_x + 8'd1;
            end
          end
        end
        DRAIN:   drain_cnt <= drain_cnt + 2'd1;
        default: ;
      endcase
    end
  end

  // Valid bits travel with each issued address so the plot lines up with q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv[0] <= (state == SCAN) && !kill;
      for (int i = 1; i < ROM_LAT; i++) pv[i] <= pv[i-1] && !kill;
    end
  end

  always_ff @(posedge clk) begin
    px[0] <= rom_x;
    py[0] <= rom_y;
    for (int i = 1; i < ROM_LAT; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end

  always_comb begin
    vga_colour = q_front;
    case (sel_q)
      2'd0:    vga_colour = q_front;
      2'd1:    vga_colour = q_start;
      2'd2:    vga_colour = q_win;
      2'd3:    vga_colour = q_lose;
      default: vga_colour = q_front;
    endcase
  end

  assign vga_x = px[ROM_LAT-1];
  assign vga_y = py[ROM_LAT-1];

`ifdef TRANSPARENT_EN
  assign vga_plot = pv[ROM_LAT-1] && (vga_colour != 3'b000);
`else
  assign vga_plot = pv[ROM_LAT-1];
`endif

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Bench for screen_draw_ctrl: ROM models, a raster-order expected-pixel queue,
// a per-cycle compare process and directed literal checks.
module tb_screen_draw_ctrl;
  parameter int ROM_LAT = 1;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] pic_sel;
  logic       abort;
  logic [2:0] q_front, q_start, q_win, q_lose;
  logic [7:0] rom_x, vga_x;
  logic [6:0] rom_y, vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;
  logic [1:0] dbg_state;

  screen_draw_ctrl #(.WIDTH(W), .HEIGHT(H), .ROM_LAT(ROM_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .pic_sel(pic_sel), .abort(abort),
    .q_front(q_front), .q_start(q_start), .q_win(q_win), .q_lose(q_lose),
    .rom_x(rom_x), .rom_y(rom_y), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- picture contents ----------------
  function automatic logic [2:0] colr(input int p, input int x, input int y);
    case (p)
      0:       colr = 3'((x + y) % 8);
      1:       colr = 3'((y + 3) % 8);
      2:       colr = 3'(x % 8);
      default: colr = (x % 2 == 1) ? (3'((x / 2) % 8) | 3'd1) : 3'd0;
    endcase
  endfunction

  function automatic bit plotted(input int p, input int x, input int y);
`ifdef TRANSPARENT_EN
    plotted = (colr(p, x, y) != 3'd0);
`else
    plotted = 1'b1;
`endif
  endfunction

  function automatic int count_plots(input int p);
    int n = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (plotted(p, x, y)) n++;
    return n;
  endfunction

  // ROM loaders: address in, q valid ROM_LAT edges later.
  logic [7:0] ra_x [ROM_LAT];
  logic [6:0] ra_y [ROM_LAT];
  always @(posedge clk) begin
    ra_x[0] <= rom_x;
    ra_y[0] <= rom_y;
    for (int i = 1; i < ROM_LAT; i++) begin
      ra_x[i] <= ra_x[i-1];
      ra_y[i] <= ra_y[i-1];
    end
  end
  assign q_front = colr(0, int'(ra_x[ROM_LAT-1]), int'(ra_y[ROM_LAT-1]));
  assign q_start = colr(1, int'(ra_x[ROM_LAT-1]), int'(ra_y[ROM_LAT-1]));
  assign q_win   = colr(2, int'(ra_x[ROM_LAT-1]), int'(ra_y[ROM_LAT-1]));
  assign q_lose  = colr(3, int'(ra_x[ROM_LAT-1]), int'(ra_y[ROM_LAT-1]));

  // ---------------- scoreboard ----------------
  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } pix_t;

  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   s = 0;
  bit   m_busy = 1'b0;

  int plot_cnt = 0, done_cnt = 0, done_rel = 0;
  int first_x = -1, first_y = -1, first_rel = -1, last_x = -1, last_y = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: cycle c is the DUT state just after the edge that made cyc==c.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          s = cyc;
          for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
              if (plotted(int'(pic_sel), x, y))
                exp_q.push_back('{x: x, y: y, c: int'(colr(int'(pic_sel), x, y)),
                                  t: s + ROM_LAT + y * W + x});
        end
      end else if (abort && (cyc - 1 < s + N + ROM_LAT)) begin
        m_busy = 1'b0;
        exp_q.delete();
      end else if (cyc == s + N + ROM_LAT + 1) begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_busy && (cyc == s + N + ROM_LAT)));
      if (vga_plot) begin
        if (plot_cnt == 0) begin
          first_x   = int'(vga_x);
          first_y   = int'(vga_y);
          first_rel = cyc - s + 1;
        end
        plot_cnt++;
        last_x = int'(vga_x);
        last_y = int'(vga_y);
        if (exp_q.size() == 0) begin
          chk("unexpected_plot", 1, 0);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          chk("plot_x", int'(vga_x), e.x);
          chk("plot_y", int'(vga_y), e.y);
          chk("plot_colour", int'(vga_colour), e.c);
          chk("plot_cycle", cyc, e.t);
        end
      end else if (exp_q.size() > 0) begin
        chk("missed_plot", int'(exp_q[0].t <= cyc), 0);
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - s + 1;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic start_draw(input int p);
    @(negedge clk);
    plot_cnt = 0; done_cnt = 0; first_rel = -1; first_x = -1; first_y = -1;
    start = 1'b1;
    pic_sel = 2'(p);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < N + ROM_LAT + 50; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) break;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
  endtask

  task automatic wait_plots(input int target);
    for (int k = 0; k < N + 50; k++) begin
      @(negedge clk);
      #1;
      if (plot_cnt >= target) break;
    end
    chk("plot_target_reached", int'(plot_cnt >= target), 1);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt_at;
    start = 1'b0; pic_sel = 2'd0; abort = 1'b0; reset = 1'b1;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_plot", int'(vga_plot), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Full draw of the win picture.
    start_draw(2);
    wait_done();
    chk("t1_plot_count", plot_cnt, count_plots(2));
`ifndef TRANSPARENT_EN
    chk("t1_plot_count_lit", plot_cnt, 19200);
    chk("t1_first_x", first_x, 0);
    chk("t1_first_y", first_y, 0);
    chk("t1_first_latency", first_rel, ROM_LAT + 1);
`endif
    chk("t1_last_x", last_x, 159);
    chk("t1_last_y", last_y, 119);
    chk("t1_done_latency", done_rel, N + ROM_LAT + 1);

    // Selector changes and start re-pulses mid-draw are ignored.
    start_draw(1);
    for (int i = 0; i < 6; i++) begin
      repeat (1000) @(negedge clk);
      pic_sel = 2'(i);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    pic_sel = 2'd3;
    wait_done();
    chk("t2_plot_count", plot_cnt, count_plots(1));

    // Abort after 500 plots, then a clean full draw.
    start_draw(0);
    wait_plots(500);
    pulse_abort();
    #1;
    cnt_at = plot_cnt;
    repeat (5) @(negedge clk);
    #1;
    chk("t3_plots_at_abort", cnt_at, 500);
    chk("t3_no_plot_after_abort", plot_cnt, 500);
    chk("t3_no_done", done_cnt, 0);
    chk("t3_busy_low", int'(busy), 0);
    start_draw(3);
    wait_done();
    chk("t3_full_after_abort", plot_cnt, count_plots(3));
`ifdef TRANSPARENT_EN
    chk("t3_lose_count_lit", plot_cnt, 9600);
`else
    chk("t3_lose_count_lit", plot_cnt, 19200);
`endif
    chk("t3_done_latency", done_rel, N + ROM_LAT + 1);

    // Asynchronous reset mid-draw at pixel (80,60).
    start_draw(2);
    wait_plots(60 * W + 80 + 1);
    chk("t4_pre_reset_x", int'(vga_x), 80);
    chk("t4_pre_reset_y", int'(vga_y), 60);
    chk("t4_pre_reset_plot", int'(vga_plot), 1);
    #1 reset = 1'b1;
    #1;
    chk("t4_async_plot", int'(vga_plot), 0);
    chk("t4_async_busy", int'(busy), 0);
    chk("t4_async_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("t4_no_done", done_cnt, 0);
    start_draw(1);
    wait_plots(20);
    pulse_abort();
    chk("t4_restart_x", first_x, 0);
    chk("t4_restart_y", first_y, 0);
    chk("t4_restart_latency", first_rel, ROM_LAT + 1);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
